// File: rtl/performance_counter_op_if.sv
// performance_counter_op_if: control and snapshot bundle between a NAND op source / software and its latency monitor
//   i_window   : successful ops per window, 0 keeps the window open forever
//   i_op_start : one-cycle pulse, op issued
//   i_op_end   : one-cycle pulse, op finished; i_op_fail qualifies it
//   i_cp_cmplt : software has copied the snapshot
//   o_lat_sum, o_req_cnt, o_lat_max, o_fail_cnt, o_drop_cnt, o_sat : window statistics
//   o_ready    : snapshot frozen and valid
interface performance_counter_op_if #(
    parameter int CNT_WD = 32,
    parameter int SUM_WD = 32,
    parameter int REQ_WD = 10
);
    logic [REQ_WD-1:0] i_window;
    logic              i_op_start;
    logic              i_op_end;
    logic              i_op_fail;
    logic              i_cp_cmplt;
    logic [SUM_WD-1:0] o_lat_sum;
    logic [REQ_WD-1:0] o_req_cnt;
    logic [CNT_WD-1:0] o_lat_max;
    logic [REQ_WD-1:0] o_fail_cnt;
    logic [REQ_WD-1:0] o_drop_cnt;
    logic              o_sat;
    logic              o_ready;
    modport slave (
        input  i_window, i_op_start, i_op_end, i_op_fail, i_cp_cmplt,
        output o_lat_sum, o_req_cnt, o_lat_max, o_fail_cnt, o_drop_cnt, o_sat, o_ready
    );
    modport master (
        output i_window, i_op_start, i_op_end, i_op_fail, i_cp_cmplt,
        input  o_lat_sum, o_req_cnt, o_lat_max, o_fail_cnt, o_drop_cnt, o_sat, o_ready
    );
endinterface

// File: rtl/performance_counter_op.sv
// performance_counter_op: per-operation NAND latency monitor with windowed, saturating statistics
//   i_bus_clk   : single clock domain
//   i_bus_rst_n : asynchronous active-low reset
//   bus         : slave side of performance_counter_op_if (op pulses and window control in, snapshot out)
module performance_counter_op #(
    parameter int CNT_WD = 32,
    parameter int SUM_WD = 32,
    parameter int REQ_WD = 10
) (
    input logic                     i_bus_clk,
    input logic                     i_bus_rst_n,
    performance_counter_op_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, HOLD, CLEAR} state_t;
    localparam logic [CNT_WD-1:0] C_ONES = '1;
    state_t            state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [CNT_WD-1:0] timer_q, timer_d;
    logic [CNT_WD-1:0] max_q, max_d;
    logic [SUM_WD-1:0] sum_q, sum_d;
    logic [REQ_WD-1:0] req_q, req_d;
    logic [REQ_WD-1:0] fail_q, fail_d;
    logic [REQ_WD-1:0] drop_q, drop_d;
    logic              sat_q, sat_d;
    logic [CNT_WD-1:0] lat;
    logic [SUM_WD:0]   sum_add;
    logic              valid_end, start_new, timer_hit, accept, dropped, ok, clr;

    function automatic logic [REQ_WD-1:0] inc_r(input logic [REQ_WD-1:0] v);
        return &v ? v : v + REQ_WD'(1);
    endfunction

    always_comb begin
        valid_end  = bus.i_op_end & inflight_q;
        // the end is resolved before the start, so a same-cycle end frees the slot for the new op
        start_new  = bus.i_op_start & (~inflight_q | bus.i_op_end);
        // saturating timer+1 doubles as this cycle's latency and the timer's next value
        lat        = (timer_q == C_ONES) ? timer_q : timer_q + CNT_WD'(1);
        timer_hit  = inflight_q & ~start_new & (timer_q == C_ONES - CNT_WD'(1));
        inflight_d = start_new | (inflight_q & ~bus.i_op_end);
        timer_d    = start_new ? '0 : inflight_q ? lat : timer_q;
        accept     = valid_end & (state_q == IDLE || state_q == COUNT);
        dropped    = valid_end & ~accept;
        ok         = accept & ~bus.i_op_fail;
        clr        = state_q == CLEAR;
        sum_add    = {1'b0, sum_q} + (SUM_WD+1)'(lat);
        sum_d      = clr ? '0 : ok ? (sum_add[SUM_WD] ? '1 : sum_add[SUM_WD-1:0]) : sum_q;
        req_d      = clr ? '0 : ok ? inc_r(req_q) : req_q;
        max_d      = clr ? '0 : (ok && lat > max_q) ? lat : max_q;
        fail_d     = clr ? '0 : (accept & bus.i_op_fail) ? inc_r(fail_q) : fail_q;
        // a drop landing in the CLEAR cycle survives the clear as a count of one
        drop_d     = clr ? REQ_WD'(dropped) : dropped ? inc_r(drop_q) : drop_q;
        sat_d      = ~clr & (sat_q | timer_hit | (&sum_d) | (&req_d) | (&max_d) | (&fail_d) | (&drop_d));
    end

    always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
        if (!i_bus_rst_n) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            timer_q    <= '0;
            sum_q      <= '0;
            req_q      <= '0;
            max_q      <= '0;
            fail_q     <= '0;
            drop_q     <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            timer_q    <= timer_d;
            sum_q      <= sum_d;
            req_q      <= req_d;
            max_q      <= max_d;
            fail_q     <= fail_d;
            drop_q     <= drop_d;
            sat_q      <= sat_d;
        end
    end

    always_comb begin
        case (state_q)
            IDLE:    state_d = (bus.i_op_start | valid_end) ? COUNT : IDLE;
            COUNT:   state_d = (bus.i_window != '0 && req_q >= bus.i_window) ? HOLD : COUNT;
            HOLD:    state_d = bus.i_cp_cmplt ? CLEAR : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_comb bus.o_ready = state_q == HOLD;

    assign bus.o_lat_sum  = sum_q;
    assign bus.o_req_cnt  = req_q;
    assign bus.o_lat_max  = max_q;
    assign bus.o_fail_cnt = fail_q;
    assign bus.o_drop_cnt = drop_q;
    assign bus.o_sat      = sat_q;
endmodule
